pipe_mem_arbiter: RTL and testbench

PIPE_MEM_ARBITER -- requirements
Module: pipe_mem_arbiter

---
 rtl/pipe_mem_arbiter.sv | 115 +++++++++++
 tb/tb_pipe_mem_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mem_arbiter.sv
// pipe_mem_arbiter: shares one RAM between instruction fetch and data ports.
// One access in flight at a time; MEM has priority, bounded by a contested-grant streak.
module pipe_mem_arbiter #(
    parameter int RAM_LAT        = 1,
    parameter int MAX_MEM_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [6:0]  if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [6:0]  mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_ack,
    output logic [31:0] mem_rdata,
    output logic        ram_en,
    output logic        ram_we,
    output logic [6:0]  ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic        pipe_stall
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [2:0] MAX_S    = 3'(MAX_MEM_STREAK);
    localparam logic [1:0] LAT_INIT = 2'(RAM_LAT - 1);

    state_t      state_q, state_d;
    logic [2:0]  streak_q, streak_d;
    logic [1:0]  lat_q, lat_d;
    logic        gnt_mem_q, gnt_mem_d;
    logic        if_ack_q, if_ack_d, mem_ack_q, mem_ack_d;
    logic        mask_if_q, mask_if_d, mask_mem_q, mask_mem_d;
    logic [31:0] if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
    logic        if_el, mem_el, pick_if, pick_mem, issue;

    always_comb begin
        // a requester acked last cycle and still holding req is treated as a stale request
        if_el       = if_req & ~mask_if_q;
        mem_el      = mem_req & ~mask_mem_q;
        pick_if     = if_el & (~mem_el | (streak_q == MAX_S));
        pick_mem    = mem_el & ~pick_if;
        issue       = rst & (state_q == IDLE) & (pick_if | pick_mem);
        state_d     = state_q;
        streak_d    = streak_q;
        lat_d       = lat_q;
        gnt_mem_d   = gnt_mem_q;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;
        mask_if_d   = if_ack_q;
        mask_mem_d  = mem_ack_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        case (state_q)
            IDLE: if (issue) begin
                gnt_mem_d = pick_mem;
                streak_d  = (pick_mem & if_req) ? ((streak_q == MAX_S) ? streak_q : streak_q + 3'd1) : 3'd0;
                mem_ack_d = pick_mem & mem_we;
                state_d   = (pick_mem & mem_we) ? RESP : WAIT;
                lat_d     = LAT_INIT;
            end
            WAIT: begin
                lat_d = lat_q - 2'd1;
                if (lat_q == 2'd0) begin
                    state_d     = RESP;
                    lat_d       = 2'd0;
                    if_ack_d    = ~gnt_mem_q;
                    mem_ack_d   = gnt_mem_q;
                    if_rdata_d  = gnt_mem_q ? if_rdata_q : ram_rdata;
                    mem_rdata_d = gnt_mem_q ? ram_rdata : mem_rdata_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            streak_q    <= 3'd0;
            lat_q       <= 2'd0;
            gnt_mem_q   <= 1'b0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            mask_if_q   <= 1'b0;
            mask_mem_q  <= 1'b0;
            if_rdata_q  <= 32'd0;
            mem_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            lat_q       <= lat_d;
            gnt_mem_q   <= gnt_mem_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
            mask_if_q   <= mask_if_d;
            mask_mem_q  <= mask_mem_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign ram_en     = issue;
    assign ram_we     = issue & pick_mem & mem_we;
    assign ram_addr   = issue ? (pick_if ? if_addr : mem_addr) : 7'd0;
    assign ram_wdata  = ram_we ? mem_wdata : 32'd0;
    assign if_ack     = if_ack_q;
    assign mem_ack    = mem_ack_q;
    assign if_rdata   = if_rdata_q;
    assign mem_rdata  = mem_rdata_q;
    assign pipe_stall = (if_req & ~if_ack_q) | (mem_req & ~mem_ack_q);
endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// tb_pipe_mem_arbiter: directed and random stimulus against a transaction-timeline model.
module tb_pipe_mem_arbiter;
    localparam int LAT = 3;
    localparam int MAX = 4;

    logic        clk = 1'b0, rst = 1'b0;
    logic        if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
    logic [6:0]  if_addr = '0, mem_addr = '0;
    logic [31:0] mem_wdata = '0, ram_rdata = '0;
    logic        if_ack, mem_ack, ram_en, ram_we, pipe_stall;
    logic [31:0] if_rdata, mem_rdata, ram_wdata;
    logic [6:0]  ram_addr;

    pipe_mem_arbiter #(.RAM_LAT(LAT), .MAX_MEM_STREAK(MAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .pipe_stall(pipe_stall)
    );

    always #5 clk = ~clk;

    logic [31:0] ram_mem [128];
    int checks = 0, errors = 0, cyc = 0;
    int free_at = 0, ack_at = -10, ack_who = 0, rd_due = -1, streak_m = 0;
    logic [6:0]  rd_addr = '0;
    logic [31:0] ack_data = '0, exp_if_rd = '0, exp_mem_rd = '0, seen_rd = '0;
    logic        ack_rd = 1'b0, last_if_ack = 1'b0, last_mem_ack = 1'b0;
    logic        seen_if_ack = 1'b0, seen_mem_ack = 1'b0, seen_en = 1'b0;
    int          seen_cyc = 0;

    // One clock cycle: inputs are already driven; predict outputs from the transaction timeline.
    task automatic tick(input bit chk);
        int c = cyc;
        logic e_if_ack, e_mem_ack, idle, if_el, mem_el, p_if, p_mem, e_en, e_we, e_stall;
        logic [6:0] e_addr;
        ram_rdata = (c == rd_due) ? ram_mem[rd_addr] : $urandom;
        #1;
        e_if_ack  = (ack_at == c) && (ack_who == 1);
        e_mem_ack = (ack_at == c) && (ack_who == 2);
        if (e_if_ack) exp_if_rd = ack_data;
        if (e_mem_ack && ack_rd) exp_mem_rd = ack_data;
        idle    = rst && (c >= free_at);
        if_el   = if_req && !((c == ack_at + 1) && (ack_who == 1));
        mem_el  = mem_req && !((c == ack_at + 1) && (ack_who == 2));
        p_if    = if_el && (!mem_el || streak_m == MAX);
        p_mem   = mem_el && !p_if;
        e_en    = idle && (p_if || p_mem);
        e_we    = e_en && p_mem && mem_we;
        e_addr  = p_if ? if_addr : mem_addr;
        e_stall = (if_req && !e_if_ack) || (mem_req && !e_mem_ack);
        if (chk) begin
            checks++;
            if (ram_en !== e_en) begin errors++; $display("FAIL ram_en cyc=%0d got %b exp %b", c, ram_en, e_en); end
            if (e_en) begin
                checks += 2;
                if (ram_addr !== e_addr) begin errors++; $display("FAIL ram_addr cyc=%0d got %h exp %h", c, ram_addr, e_addr); end
                if (ram_we !== e_we) begin errors++; $display("FAIL ram_we cyc=%0d got %b exp %b", c, ram_we, e_we); end
                if (e_we) begin
                    checks++;
                    if (ram_wdata !== mem_wdata) begin errors++; $display("FAIL ram_wdata cyc=%0d got %h exp %h", c, ram_wdata, mem_wdata); end
                end
            end
            if (!rst) begin
                checks++;
                if ({ram_we, ram_addr, ram_wdata} !== 40'd0) begin errors++; $display("FAIL ram_zero_in_reset cyc=%0d got we=%b addr=%h wdata=%h exp all 0", c, ram_we, ram_addr, ram_wdata); end
            end
            checks += 5;
            if (if_ack !== e_if_ack) begin errors++; $display("FAIL if_ack cyc=%0d got %b exp %b", c, if_ack, e_if_ack); end
            if (mem_ack !== e_mem_ack) begin errors++; $display("FAIL mem_ack cyc=%0d got %b exp %b", c, mem_ack, e_mem_ack); end
            if (if_rdata !== exp_if_rd) begin errors++; $display("FAIL if_rdata cyc=%0d got %h exp %h", c, if_rdata, exp_if_rd); end
            if (mem_rdata !== exp_mem_rd) begin errors++; $display("FAIL mem_rdata cyc=%0d got %h exp %h", c, mem_rdata, exp_mem_rd); end
            if (pipe_stall !== e_stall) begin errors++; $display("FAIL pipe_stall cyc=%0d got %b exp %b", c, pipe_stall, e_stall); end
        end
        seen_if_ack = if_ack;
        seen_mem_ack = mem_ack;
        seen_en = ram_en;
        seen_rd = mem_ack ? mem_rdata : if_rdata;
        seen_cyc = c;
        last_if_ack = e_if_ack;
        last_mem_ack = e_mem_ack;
        if (!rst) begin
            free_at = c + 1; ack_at = -10; ack_who = 0; rd_due = -1; streak_m = 0;
            exp_if_rd = '0; exp_mem_rd = '0;
        end else if (e_en) begin
            streak_m = (p_mem && if_req) ? ((streak_m + 1 > MAX) ? MAX : streak_m + 1) : 0;
            ack_who  = p_if ? 1 : 2;
            ack_rd   = !e_we;
            ack_at   = e_we ? c + 1 : c + LAT + 1;
            free_at  = ack_at + 1;
            if (e_we) ram_mem[e_addr] = mem_wdata;
            else begin rd_due = c + LAT; rd_addr = e_addr; ack_data = ram_mem[e_addr]; end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Waits (bounded) for the ack of one port, optionally checking its data, then drops or keeps req.
    task automatic wait_ack(input bit want_mem, input bit chk_data, input logic [31:0] want, input bit drop, output int at);
        at = -1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (want_mem ? seen_mem_ack : seen_if_ack) begin
                at = seen_cyc;
                if (chk_data) begin
                    checks++;
                    if (seen_rd !== want) begin errors++; $display("FAIL ack_data port=%0d got %h exp %h", want_mem, seen_rd, want); end
                end
                if (drop) begin if (want_mem) mem_req = 1'b0; else if_req = 1'b0; end
                return;
            end
        end
        errors++;
        $display("FAIL ack_timeout port=%0d got no ack exp ack within 20 cycles", want_mem);
    endtask

    task automatic test_reset();
        rst = 1'b0; if_req = 1'b1; mem_req = 1'b1; mem_we = 1'b1;
        tick(0);
        tick(1);
        rst = 1'b1; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        tick(1);
        tick(1);
    endtask

    task automatic test_if_fetch();
        int c0, at;
        ram_mem[5] = 32'h2002_0004;
        if_req = 1'b1; if_addr = 7'h05; c0 = cyc;
        wait_ack(1'b0, 1'b1, 32'h2002_0004, 1'b1, at);
        checks++;
        if (at - c0 !== LAT + 1) begin errors++; $display("FAIL fetch_latency got %0d exp %0d", at - c0, LAT + 1); end
        tick(1);
    endtask

    task automatic test_contention();
        int c0, at;
        if_req = 1'b1; if_addr = 7'h03;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 7'h10; mem_wdata = 32'hDEAD_BEEF; c0 = cyc;
        wait_ack(1'b1, 1'b0, 32'd0, 1'b1, at);
        checks++;
        if (at - c0 !== 1) begin errors++; $display("FAIL write_ack_latency got %0d exp 1", at - c0); end
        mem_we = 1'b0;
        wait_ack(1'b0, 1'b0, 32'd0, 1'b1, at);
        checks++;
        if (at - c0 !== LAT + 3) begin errors++; $display("FAIL if_after_write got %0d exp %0d", at - c0, LAT + 3); end
        tick(1);
    endtask

    task automatic test_wrap();
        int c0, at;
        ram_mem[127] = 32'hA5A5_1234;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 7'h7F; c0 = cyc;
        tick(1);
        mem_addr = 7'h00; mem_wdata = $urandom;
        wait_ack(1'b1, 1'b1, 32'hA5A5_1234, 1'b1, at);
        checks++;
        if (at - c0 !== LAT + 1) begin errors++; $display("FAIL wrap_latency got %0d exp %0d", at - c0, LAT + 1); end
        tick(1);
    endtask

    task automatic test_reset_mid();
        int at;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 7'h22;
        tick(1);
        tick(1);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(1);
        checks++;
        if (seen_en !== 1'b1) begin errors++; $display("FAIL reissue_after_reset got %b exp 1", seen_en); end
        wait_ack(1'b1, 1'b1, ram_mem[7'h22], 1'b1, at);
        tick(1);
    endtask

    task automatic test_back_to_back();
        int a0, a1;
        if_req = 1'b1; if_addr = 7'h40;
        wait_ack(1'b0, 1'b0, 32'd0, 1'b0, a0);
        if_addr = 7'h41;
        wait_ack(1'b0, 1'b0, 32'd0, 1'b1, a1);
        checks++;
        if (a1 - a0 !== LAT + 3) begin errors++; $display("FAIL held_req_spacing got %0d exp %0d", a1 - a0, LAT + 3); end
        tick(1);
    endtask

    task automatic test_random(input int n);
        bit new_mem;
        for (int i = 0; i < n; i++) begin
            if (if_req && last_if_ack) if_req = 1'($urandom_range(0, 1));
            else if (!if_req) if_req = ($urandom_range(0, 2) == 0);
            if (mem_req && last_mem_ack) begin mem_req = 1'($urandom_range(0, 1)); new_mem = mem_req; end
            else if (!mem_req) begin mem_req = ($urandom_range(0, 2) == 0); new_mem = mem_req; end
            else new_mem = 1'b0;
            if (new_mem) mem_we = 1'($urandom_range(0, 1));
            if_addr = 7'($urandom);
            mem_addr = 7'($urandom);
            mem_wdata = $urandom;
            tick(1);
        end
        if_req = 1'b0; mem_req = 1'b0;
        for (int i = 0; i < LAT + 4; i++) tick(1);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) ram_mem[i] = $urandom;
        @(negedge clk);
        test_reset();
        test_if_fetch();
        test_contention();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        test_random(600);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
